// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 raster constants and sync/blank control word
package vga_timing_pkg;

  localparam int H_ACTIVE   = 640;
  localparam int H_FP       = 16;
  localparam int H_SYNC     = 96;
  localparam int H_BP       = 48;
  localparam int V_ACTIVE   = 480;
  localparam int V_FP       = 10;
  localparam int V_SYNC     = 2;
  localparam int V_BP       = 33;
  localparam int PIPE_DELAY = 1;

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CNT_W   = 11;

  typedef struct packed {
    logic hs;
    logic vs;
    logic active;
  } vga_ctrl_t;

  localparam vga_ctrl_t VGA_CTRL_BLANK = '{hs: 1'b1, vs: 1'b1, active: 1'b0};

endpackage

// File: rtl/vga_sync_gen_if.sv
// rtl/vga_sync_gen_if.sv - colour-in, coordinate and DAC pin bundle of the sync generator
interface vga_sync_gen_if;

  logic [7:0]  redIn;
  logic [7:0]  greenIn;
  logic [7:0]  blueIn;
  logic [10:0] pixelX;
  logic [10:0] pixelY;
  logic        displayActive;
  logic        startOfFrame;
  logic        vgaHS;
  logic        vgaVS;
  logic        vgaBlankN;
  logic [7:0]  vgaR;
  logic [7:0]  vgaG;
  logic [7:0]  vgaB;

  // master: the timing generator; slave: the object mux / display side
  modport master (
    input  redIn, greenIn, blueIn,
    output pixelX, pixelY, displayActive, startOfFrame,
    output vgaHS, vgaVS, vgaBlankN, vgaR, vgaG, vgaB
  );

  modport slave (
    output redIn, greenIn, blueIn,
    input  pixelX, pixelY, displayActive, startOfFrame,
    input  vgaHS, vgaVS, vgaBlankN, vgaR, vgaG, vgaB
  );

endinterface

// File: rtl/vga_ctrl_delay.sv
// rtl/vga_ctrl_delay.sv - shift register for sync/active, every tap exposed (tap 0 = input)
module vga_ctrl_delay
  import vga_timing_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  resetN,
  input  vga_ctrl_t             din,
  output vga_ctrl_t [DEPTH:0]   taps
);

  vga_ctrl_t [DEPTH:1] stage_q;
  vga_ctrl_t [DEPTH:1] stage_d;

  always_comb begin
    stage_d    = stage_q;
    stage_d[1] = din;
    for (int i = 2; i <= DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      stage_q <= {DEPTH{VGA_CTRL_BLANK}};
    end else begin
      stage_q <= stage_d;
    end
  end

  assign taps = {stage_q, din};

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA raster counters, sync/blank decode and blanked colour register to the DAC
module vga_sync_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE   = vga_timing_pkg::H_ACTIVE,
  parameter int H_FP       = vga_timing_pkg::H_FP,
  parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
  parameter int H_BP       = vga_timing_pkg::H_BP,
  parameter int V_ACTIVE   = vga_timing_pkg::V_ACTIVE,
  parameter int V_FP       = vga_timing_pkg::V_FP,
  parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
  parameter int V_BP       = vga_timing_pkg::V_BP,
  parameter int PIPE_DELAY = vga_timing_pkg::PIPE_DELAY
) (
  input  logic          clk,
  input  logic          resetN,
  vga_sync_gen_if.master vif
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DEPTH = PIPE_DELAY + 1;

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  logic [23:0]      rgb_q, rgb_d;

  vga_ctrl_t              ctrl_raw;
  vga_ctrl_t [DEPTH:0]    ctrl_taps;
  logic                   active_raw;

  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == CNT_W'(H_TOT - 1)) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == CNT_W'(V_TOT - 1)) ? '0 : v_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign active_raw = (h_cnt_q < CNT_W'(H_ACTIVE)) && (v_cnt_q < CNT_W'(V_ACTIVE));

  always_comb begin
    ctrl_raw.hs     = !((h_cnt_q >= CNT_W'(H_ACTIVE + H_FP)) &&
                        (h_cnt_q <  CNT_W'(H_ACTIVE + H_FP + H_SYNC)));
    ctrl_raw.vs     = !((v_cnt_q >= CNT_W'(V_ACTIVE + V_FP)) &&
                        (v_cnt_q <  CNT_W'(V_ACTIVE + V_FP + V_SYNC)));
    ctrl_raw.active = active_raw;
  end

  vga_ctrl_delay #(.DEPTH(DEPTH)) u_ctrl_delay (
    .clk    (clk),
    .resetN (resetN),
    .din    (ctrl_raw),
    .taps   (ctrl_taps)
  );

  // Gate colour with the active flag one stage early so it lands with vgaBlankN
  always_comb begin
    rgb_d = '0;
    if (ctrl_taps[PIPE_DELAY].active) begin
      rgb_d = {vif.redIn, vif.greenIn, vif.blueIn};
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rgb_q <= '0;
    end else begin
      rgb_q <= rgb_d;
    end
  end

  assign vif.pixelX        = h_cnt_q;
  assign vif.pixelY        = v_cnt_q;
  assign vif.displayActive = active_raw;
  assign vif.startOfFrame  = (h_cnt_q == '0) && (v_cnt_q == '0);
  assign vif.vgaHS         = ctrl_taps[DEPTH].hs;
  assign vif.vgaVS         = ctrl_taps[DEPTH].vs;
  assign vif.vgaBlankN     = ctrl_taps[DEPTH].active;
  assign vif.vgaR          = rgb_q[23:16];
  assign vif.vgaG          = rgb_q[15:8];
  assign vif.vgaB          = rgb_q[7:0];

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - scoreboard bench for vga_sync_gen on a shrunken raster
module tb_vga_sync_gen;
  import vga_timing_pkg::*;

  localparam int HA = 16, HF = 3, HS = 4, HB = 5;
  localparam int VA = 6,  VF = 2, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        blank_n;
    logic [23:0] rgb;
  } exp_t;

  localparam exp_t EXP_BLANK = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0, rgb: 24'h0};

  logic clk    = 1'b0;
  logic resetN = 1'b0;
  always #5 clk = ~clk;

  vga_sync_gen_if vif ();

  vga_sync_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PIPE_DELAY(1)
  ) dut (
    .clk    (clk),
    .resetN (resetN),
    .vif    (vif.master)
  );

  int    n_checks = 0;
  int    n_pass   = 0;
  exp_t  exp_q[$];
  int    mh = 0, mv = 0;
  int    cyc = 0, last_sof = 0;
  int    hs_run = 0, vs_run = 0, blank_run = 0;
  bit    mode_ff = 1'b0;
  logic [23:0] pend = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h expected=%0h (cycle %0d, model x=%0d y=%0d)", tag, got, exp, cyc, mh, mv);
  endtask

  function automatic exp_t model_out(input int h, input int v, input bit m);
    exp_t e;
    e.hs      = !(h >= HA + HF && h < HA + HF + HS);
    e.vs      = !(v >= VA + VF && v < VA + VF + VS);
    e.blank_n = (h < HA) && (v < VA);
    e.rgb     = !e.blank_n ? 24'h0 : (m ? 24'hFFFFFF : {h[7:0], v[7:0], 8'hA5});
    return e;
  endfunction

  function automatic exp_t dut_out();
    exp_t e;
    e.hs      = vif.vgaHS;
    e.vs      = vif.vgaVS;
    e.blank_n = vif.vgaBlankN;
    e.rgb     = {vif.vgaR, vif.vgaG, vif.vgaB};
    return e;
  endfunction

  task automatic advance_model();
    if (mh == HT - 1) begin
      mh = 0;
      mv = (mv == VT - 1) ? 0 : mv + 1;
    end else begin
      mh++;
    end
  endtask

  task automatic check_coords();
    check_eq("pixelX", 32'(vif.pixelX), 32'(mh));
    check_eq("pixelY", 32'(vif.pixelY), 32'(mv));
    check_eq("displayActive", 32'(vif.displayActive), 32'((mh < HA) && (mv < VA)));
    check_eq("startOfFrame", 32'(vif.startOfFrame), 32'((mh == 0) && (mv == 0)));
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    if (resetN) advance_model();
    cyc++;
    @(negedge clk);
    if (!resetN) begin
      check_eq("reset_outputs", 32'(dut_out()), 32'(EXP_BLANK));
    end else begin
      if (exp_q.size() == 0) begin
        check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check_eq("sync_blank_rgb", 32'(dut_out()), 32'(e));
      end
      if (!vif.vgaHS) hs_run++;
      else if (hs_run > 0) begin check_eq("hs_width", 32'(hs_run), 32'(HS)); hs_run = 0; end
      if (!vif.vgaVS) vs_run++;
      else if (vs_run > 0) begin check_eq("vs_width", 32'(vs_run), 32'(VS * HT)); vs_run = 0; end
      if (vif.vgaBlankN) blank_run++;
      else if (blank_run > 0) begin check_eq("blank_width", 32'(blank_run), 32'(HA)); blank_run = 0; end
      if (vif.startOfFrame) begin
        check_eq("sof_period", 32'(cyc - last_sof), 32'(HT * VT));
        last_sof = cyc;
      end
    end
    check_coords();
    // Object-mux model: one register stage from coordinates to colour
    {vif.redIn, vif.greenIn, vif.blueIn} = pend;
    pend = mode_ff ? 24'hFFFFFF : {vif.pixelX[7:0], vif.pixelY[7:0], 8'hA5};
    if (resetN) exp_q.push_back(model_out(mh, mv, mode_ff));
  endtask

  task automatic release_reset();
    resetN = 1'b1;
    exp_q.delete();
    exp_q.push_back(EXP_BLANK);
    exp_q.push_back(model_out(0, 0, mode_ff));
    last_sof  = cyc;
    hs_run    = 0;
    vs_run    = 0;
    blank_run = 0;
  endtask

  task automatic async_reset_mid_frame();
    @(posedge clk);
    advance_model();
    cyc++;
    #2;
    resetN = 1'b0;
    mh = 0;
    mv = 0;
    #1;
    check_eq("async_reset_outputs", 32'(dut_out()), 32'(EXP_BLANK));
    check_coords();
    exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    {vif.redIn, vif.greenIn, vif.blueIn} = 24'h0;
    @(negedge clk);
    check_eq("reset_outputs_t0", 32'(dut_out()), 32'(EXP_BLANK));
    check_coords();
    for (int i = 0; i < 5; i++) step();
    release_reset();

    for (int i = 0; i < 2 * HT * VT + 10; i++) step();

    mode_ff = 1'b1;
    for (int i = 0; i < HT * VT + 3; i++) step();

    mode_ff = 1'b0;
    for (int i = 0; i < 2 * HT * VT && !(mh == 9 && mv == 3); i++) step();
    check_eq("reached_reset_point", 32'(mh == 9 && mv == 3), 32'd1);
    async_reset_mid_frame();
    for (int i = 0; i < 3; i++) step();
    release_reset();
    for (int i = 0; i < HT * VT + 5; i++) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Downstream display stage for the object mux: generates 640x480@60 Hz VGA raster timing and the pixelX/pixelY coordinates that drive every drawing object. It also takes back the mux's 24-bit colour and registers it to the DAC pins. Sync and blank are delayed so they line up with colour that has passed through the drawing objects and the one-cycle registered mux. Runs on the 25.175 MHz pixel clock.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width
- V_BP, 33, vertical back porch
- PIPE_DELAY, 1, register stages between pixelX/Y and the mux colour output

Ports:
- clk  in  1  pixel clock
- resetN  in  1  asynchronous, active-low reset
- redIn / greenIn / blueIn  in  8 each  colour from the object mux
- pixelX  out  11  current horizontal count, 0..H_TOTAL-1
- pixelY  out  11  current vertical count, 0..V_TOTAL-1
- displayActive  out  1  pixelX<H_ACTIVE and pixelY<V_ACTIVE (undelayed)
- startOfFrame  out  1  high while pixelX==0 and pixelY==0
- vgaHS, vgaVS  out  1 each  active-low syncs, aligned to vgaR/G/B
- vgaBlankN  out  1  high during visible pixels, aligned to vgaR/G/B
- vgaR / vgaG / vgaB  out  8 each  registered colour, forced 0 when blanked

## Operation
- Totals: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800) and V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- The horizontal counter hCnt increments every clock and wraps at H_TOTAL-1 to 0.
- The vertical counter vCnt increments only on the hCnt wrap, and wraps at V_TOTAL-1 to 0.
- pixelX and pixelY are the counter registers, driven directly.
- Raw decodes, combinational from the counters:
  - hsRaw is low while H_ACTIVE+H_FP <= hCnt < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vsRaw is low while V_ACTIVE+V_FP <= vCnt < V_ACTIVE+V_FP+V_SYNC (490..491).
  - activeRaw = displayActive.
- Delay line: {hsRaw, vsRaw, activeRaw} passes through PIPE_DELAY+1 register stages to become {vgaHS, vgaVS, vgaBlankN}.
- Colour output: the final stage registers vgaR/G/B <= delayed-active ? colourIn : 0. The delayed-active used here is the one at stage PIPE_DELAY, so that colour and vgaBlankN update in the same clock edge.
- Reset is asynchronous and may occur mid-frame. All of the following take effect immediately:
  - hCnt=0, vCnt=0.
  - Every delay stage loads its blank state: HS=1, VS=1, active=0.
  - vgaR/G/B=0.
- After reset release the raster restarts at (0,0). No partial frame is resumed.

## Timing
- Reset values:
  - pixelX=0, pixelY=0.
  - displayActive=1 and startOfFrame=1 (both are combinational decodes of (0,0)).
  - vgaHS=1, vgaVS=1, vgaBlankN=0, vgaR/G/B=0.
- Latency: counter value at edge t appears as vgaHS/vgaVS/vgaBlankN/vgaR/G/B after edge t+PIPE_DELAY+1. With the default this is 2 clocks.
- startOfFrame is high for exactly one clock per frame (every 420000 clocks), and also in the first clock after reset.
- vgaHS low for exactly H_SYNC clocks per line. vgaVS low for exactly V_SYNC*H_TOTAL clocks, with both edges coincident with a delayed hCnt==0.
- vgaBlankN high for H_ACTIVE consecutive clocks on each of the V_ACTIVE visible lines.

## Structure
- Package vga_timing_pkg holds:
  - the default timing constants;
  - derived H_TOTAL/V_TOTAL;
  - a packed struct vga_ctrl_t {hs, vs, active};
  - the localparam VGA_CTRL_BLANK = '{1,1,0}.
- One sub-module, vga_ctrl_delay:
  - parameterised depth shift register of vga_ctrl_t;
  - async reset to VGA_CTRL_BLANK.
- The counters, decodes and colour register live in vga_sync_gen.

## Test plan
- Reset, then hold resetN=0 for 5 clocks -> vgaHS=vgaVS=1, vgaBlankN=0, RGB=0, pixelX=pixelY=0.
- Free-run 2 frames -> startOfFrame pulses are exactly 420000 clocks apart; pixelX reaches 799 then 0; pixelY reaches 524 then 0.
- Observe one line -> vgaHS falls 2 clocks after pixelX==656 and rises 2 clocks after pixelX==752; vgaBlankN is high for 640 clocks.
- Model the mux as a 1-cycle register of colour = {pixelX[7:0], pixelY[7:0], 8'hA5} -> at vgaBlankN rise the outputs are vgaR=0, vgaG=0, vgaB=8'hA5. Every visible pixel matches its coordinates.
- Drive colour 8'hFF constantly -> RGB=0 whenever vgaBlankN=0, including both porches and vsync lines.
- Assert resetN low at pixelX=300, pixelY=200 -> all outputs are at reset values within the same cycle. After release, counting resumes from (0,0) and a full frame follows.
